// File: rtl/requant_clamp.sv
// Per-lane requantiser: optional round-half-up, arithmetic right shift, then clamp or ReLU
// down to OUTPUT_DW bits. Two-stage valid/ready pipeline with a saturating clamp counter.
module requant_clamp #(
   parameter int NUM_CH    = 4,
   parameter int INPUT_DW  = 32,
   parameter int OUTPUT_DW = 8,
   parameter int SHIFT_W   = 5,
   parameter int CNT_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [SHIFT_W-1:0]            cfg_shift,
   input  logic                          cfg_round,
   input  logic                          cfg_relu,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_CH*INPUT_DW-1:0]    in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_CH*OUTPUT_DW-1:0]   out_data,
   output logic [NUM_CH-1:0]             out_sat,
   output logic [CNT_W-1:0]              sat_cnt,
   input  logic                          sat_cnt_clr
);

   localparam int W1  = INPUT_DW + 1;
   localparam int PCW = $clog2(NUM_CH + 1);
   localparam int CW1 = CNT_W + 1;
   localparam logic signed [W1-1:0] OMAX = W1'(2**(OUTPUT_DW-1) - 1);
   localparam logic signed [W1-1:0] OMIN = -OMAX - W1'(1);

   logic                              v1;
   logic                              v2;
   logic [NUM_CH-1:0][W1-1:0]         s1_data;
   logic                              s1_relu;
   logic [NUM_CH-1:0][OUTPUT_DW-1:0]  s2_data;

   logic [NUM_CH-1:0][W1-1:0]         s1_next;
   logic [NUM_CH-1:0][OUTPUT_DW-1:0]  s2_next;
   logic [NUM_CH-1:0]                 sat_next;
   logic [31:0]                       sh;
   logic signed [W1-1:0]              bias;
   logic signed [W1-1:0]              x;
   logic signed [W1-1:0]              sum;
   logic signed [W1-1:0]              r;
   logic [PCW-1:0]                    pop;
   logic [CW1-1:0]                    cnt_sum;
   logic                              accept;
   logic                              s2_load;
   logic                              out_fire;

   assign in_ready = !v1 || !v2 || out_ready;
   assign accept   = in_valid && in_ready;
   assign s2_load  = v1 && (!v2 || out_ready);
   assign out_fire = v2 && out_ready;
   assign out_valid = v2;
   assign out_data  = s2_data;

   // Stage 1 arithmetic is one bit wider than the input so the rounding bias can never overflow.
   always_comb begin
      sh = 32'(cfg_shift);
      if (sh >= 32'(INPUT_DW)) sh = 32'(INPUT_DW - 1);
      bias = '0;
      if (cfg_round && (sh != 32'd0)) bias = W1'(1) << (sh - 32'd1);
      x   = '0;
      sum = '0;
      s1_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         x   = {in_data[i*INPUT_DW + INPUT_DW - 1], in_data[i*INPUT_DW +: INPUT_DW]};
         sum = x + bias;
         s1_next[i] = sum >>> sh;
      end
   end

   always_comb begin
      r = '0;
      s2_next  = '0;
      sat_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         r = signed'(s1_data[i]);
         if (s1_relu && r[W1-1]) begin
            s2_next[i] = '0;
         end else if (r > OMAX) begin
            s2_next[i]  = OMAX[OUTPUT_DW-1:0];
            sat_next[i] = 1'b1;
         end else if (r < OMIN) begin
            s2_next[i]  = OMIN[OUTPUT_DW-1:0];
            sat_next[i] = 1'b1;
         end else begin
            s2_next[i] = r[OUTPUT_DW-1:0];
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CH; i++) pop = pop + PCW'(out_sat[i]);
      cnt_sum = CW1'(sat_cnt) + CW1'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         s1_data <= '0;
         s1_relu <= 1'b0;
         s2_data <= '0;
         out_sat <= '0;
         sat_cnt <= '0;
      end else begin
         if (accept) begin
            v1      <= 1'b1;
            s1_data <= s1_next;
            s1_relu <= cfg_relu;
         end else if (s2_load) begin
            v1 <= 1'b0;
         end

         if (s2_load) begin
            v2      <= 1'b1;
            s2_data <= s2_next;
            out_sat <= sat_next;
         end else if (out_fire) begin
            v2 <= 1'b0;
         end

         // Clear takes priority and discards the count of a beat handed off on the same edge.
         if (sat_cnt_clr) begin
            sat_cnt <= '0;
         end else if (out_fire) begin
            sat_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_requant_clamp.sv
// Randomised and directed bench for requant_clamp; a queue-based reference model checks
// every cycle while literal vectors pin the model's arithmetic.
module tb_requant_clamp;

   localparam int NUM_CH = 4;
   localparam int IDW    = 32;
   localparam int ODW    = 8;
   localparam int SW     = 6;
   localparam int CW     = 6;
   localparam longint OMAX = (longint'(1) << (ODW - 1)) - 1;
   localparam longint OMIN = -(longint'(1) << (ODW - 1));
   localparam longint CMAX = (longint'(1) << CW) - 1;

   typedef struct {
      logic [NUM_CH*ODW-1:0] data;
      logic [NUM_CH-1:0]     sat;
      int                    acc;
   } beat_t;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [SW-1:0]             cfg_shift;
   logic                      cfg_round;
   logic                      cfg_relu;
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_CH*IDW-1:0]     in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [NUM_CH*ODW-1:0]     out_data;
   logic [NUM_CH-1:0]         out_sat;
   logic [CW-1:0]             sat_cnt;
   logic                      sat_cnt_clr;

   int     tests = 0;
   int     fails = 0;
   int     cyc   = 0;
   longint mcnt  = 0;
   beat_t  expq[$];

   requant_clamp #(
      .NUM_CH(NUM_CH), .INPUT_DW(IDW), .OUTPUT_DW(ODW), .SHIFT_W(SW), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_round(cfg_round),
      .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic beat_t model_beat(input logic [NUM_CH*IDW-1:0] d, input int shift,
                                        input bit rnd, input bit relu);
      beat_t  b;
      longint v;
      int     s;
      b.data = '0;
      b.sat  = '0;
      b.acc  = 0;
      s = (shift >= IDW) ? IDW - 1 : shift;
      for (int i = 0; i < NUM_CH; i++) begin
         v = longint'($signed(d[i*IDW +: IDW]));
         if (rnd && s > 0) v = v + (longint'(1) << (s - 1));
         v = v >>> s;
         if (relu && v < 0) begin
            v = 0;
         end else if (v > OMAX) begin
            v = OMAX;
            b.sat[i] = 1'b1;
         end else if (v < OMIN) begin
            v = OMIN;
            b.sat[i] = 1'b1;
         end
         b.data[i*ODW +: ODW] = v[ODW-1:0];
      end
      return b;
   endfunction

   // Reference monitor: sampled mid-cycle, when inputs and outputs are both settled.
   always @(negedge clk) begin
      beat_t  b;
      longint pc;
      cyc++;
      if (!rst_n) begin
         expq.delete();
         mcnt = 0;
         check("rst_out_valid", out_valid, 0);
         check("rst_sat_cnt", sat_cnt, 0);
         check("rst_in_ready", in_ready, 1);
      end else begin
         check("in_ready", in_ready, (expq.size() < 2) || out_ready);
         check("sat_cnt", sat_cnt, mcnt);
         check("out_valid", out_valid, (expq.size() > 0) && (cyc >= expq[0].acc + 2));
         if (out_valid && expq.size() > 0) begin
            check("out_data", out_data, expq[0].data);
            check("out_sat", out_sat, expq[0].sat);
         end
         pc = 0;
         if (out_valid && out_ready && expq.size() > 0) begin
            for (int i = 0; i < NUM_CH; i++) pc += expq[0].sat[i];
            void'(expq.pop_front());
         end
         if (sat_cnt_clr) mcnt = 0;
         else if (out_valid && out_ready) mcnt = (mcnt + pc > CMAX) ? CMAX : mcnt + pc;
         if (in_valid && in_ready) begin
            b = model_beat(in_data, int'(cfg_shift), cfg_round, cfg_relu);
            b.acc = cyc;
            expq.push_back(b);
         end
      end
   end

   // Offers one beat to an idle pipeline and checks that it takes exactly two edges to appear.
   task automatic applyStimulus(input logic [31:0] l0, input logic [31:0] l1,
                                input logic [31:0] l2, input logic [31:0] l3,
                                input int shift, input bit rnd, input bit relu);
      in_data   = {l3, l2, l1, l0};
      cfg_shift = SW'(shift);
      cfg_round = rnd;
      cfg_relu  = relu;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("latency_early", out_valid, 0);
      @(posedge clk); #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] exp_data,
                              input logic [3:0] exp_sat, input int exp_cnt, input bit clr);
      check({name, "_valid"}, out_valid, 1);
      check({name, "_data"}, out_data, exp_data);
      check({name, "_sat"}, out_sat, exp_sat);
      sat_cnt_clr = clr;
      @(posedge clk); #1;
      sat_cnt_clr = 1'b0;
      check({name, "_cnt"}, sat_cnt, exp_cnt);
   endtask

   initial begin
      logic [NUM_CH*IDW-1:0] bp [4];
      int  k;
      bit  acc;
      int  mode;
      logic [31:0] lane;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_cnt_clr = 1'b0;
      cfg_shift = '0; cfg_round = 1'b0; cfg_relu = 1'b0; in_data = '0;
      #1;
      check("reset_ready", in_ready, 1);
      check("reset_out_data", out_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus(32'd100, -32'sd100, 32'd127, -32'sd128, 0, 0, 0);
      checkOutput("passthru", 32'h807F9C64, 4'b0000, 0, 0);
      applyStimulus(32'd200, -32'sd200, 32'h7FFFFFFF, 32'h80000000, 0, 0, 0);
      checkOutput("clamp_all", 32'h807F807F, 4'b1111, 4, 0);
      applyStimulus(32'd24, -32'sd24, 32'd23, 32'h7FFFFFFF, 4, 1, 0);
      checkOutput("round_shift", 32'h7F01FF02, 4'b1000, 5, 0);
      applyStimulus(-32'sd5, 32'd300, -32'sd300, 32'd7, 0, 0, 1);
      checkOutput("relu", 32'h07007F00, 4'b0010, 6, 0);
      applyStimulus(32'd5, -32'sd3, 32'd100, -32'sd100, 0, 1, 0);
      checkOutput("shift0_round", 32'h9C64FD05, 4'b0000, 6, 0);
      applyStimulus(32'h80000000, 32'h7FFFFFFF, 32'h40000000, 32'd5, 40, 1, 0);
      checkOutput("shift_cap", 32'h000101FF, 4'b0000, 6, 0);

      // Backpressure: downstream stalls for three cycles after the first output.
      bp[0] = {32'd4, 32'd3, 32'd2, 32'd1};
      bp[1] = {32'd500, -32'sd9, 32'd0, 32'd10};
      bp[2] = {-32'sd1000, 32'd20, 32'd30, 32'd40};
      bp[3] = {32'd50, 32'd60, 32'd70, 32'd80};
      cfg_shift = '0; cfg_round = 1'b0; cfg_relu = 1'b0;
      k = 0;
      for (int c = 0; c < 20; c++) begin
         in_valid  = (k < 4);
         in_data   = bp[(k < 4) ? k : 3];
         out_ready = !(c >= 2 && c <= 4);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (c == 2) check("bp_ready_low", in_ready, 0);
         if (c >= 2 && c <= 4) check("bp_hold", out_data, 32'h04030201);
         @(posedge clk); #1;
         if (acc) k++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_all_accepted", k, 4);

      applyStimulus(32'd200, -32'sd200, 32'h7FFFFFFF, 32'h80000000, 0, 0, 0);
      checkOutput("clr_wins", 32'h807F807F, 4'b1111, 0, 1);
      applyStimulus(32'd200, -32'sd200, 32'h7FFFFFFF, 32'h80000000, 0, 0, 0);
      checkOutput("pre_rst_a", 32'h807F807F, 4'b1111, 4, 0);
      applyStimulus(32'd200, -32'sd200, 32'h7FFFFFFF, 32'h80000000, 0, 0, 0);
      checkOutput("pre_rst_b", 32'h807F807F, 4'b1111, 8, 0);
      applyStimulus(32'd24, -32'sd24, 32'd23, 32'h7FFFFFFF, 4, 1, 0);
      checkOutput("pre_rst_c", 32'h7F01FF02, 4'b1000, 9, 0);

      // Asynchronous reset with a beat waiting at the output.
      applyStimulus(32'd200, 32'd1, 32'd2, 32'd3, 0, 0, 0);
      out_ready = 1'b0;
      #1;
      check("pre_rst_valid", out_valid, 1);
      check("pre_rst_cnt", sat_cnt, 9);
      rst_n = 1'b0;
      #1;
      check("async_valid", out_valid, 0);
      check("async_cnt", sat_cnt, 0);
      check("async_sat", out_sat, 0);
      check("async_data", out_data, 0);
      check("async_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("no_stale_beat", out_valid, 0);
      end
      applyStimulus(32'd100, -32'sd100, 32'd127, -32'sd128, 0, 0, 0);
      checkOutput("post_rst", 32'h807F9C64, 4'b0000, 0, 0);

      // Random traffic; the monitor carries all checking here.
      for (int c = 0; c < 3000; c++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         sat_cnt_clr = ($urandom_range(0, 199) == 0);
         cfg_round   = $urandom_range(0, 1);
         cfg_relu    = ($urandom_range(0, 3) == 0);
         cfg_shift   = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 63))
                                                  : SW'($urandom_range(0, 10));
         for (int i = 0; i < NUM_CH; i++) begin
            mode = $urandom_range(0, 3);
            if (mode == 0) lane = 32'($urandom_range(0, 800)) - 32'd400;
            else if (mode == 1) lane = 32'($urandom_range(0, 8000)) - 32'd4000;
            else if (mode == 2) lane = ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
            else lane = $urandom;
            in_data[i*IDW +: IDW] = lane;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1; sat_cnt_clr = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("drain_empty", expq.size(), 0);
      check("drain_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
